// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped UART transmitter.
//   TX_DATA_ADDR / STATUS_ADDR : word addresses decoded on the MEM-stage data bus
//   STAT_*                     : bit positions inside the status word
//   tx_state_t                 : serialiser states
package mmio_pkg;

   localparam int unsigned TX_DATA_ADDR = 32'h0000_7FF0;
   localparam int unsigned STATUS_ADDR  = 32'h0000_7FF1;

   localparam int unsigned STAT_FULL_BIT  = 0;
   localparam int unsigned STAT_EMPTY_BIT = 1;
   localparam int unsigned STAT_BUSY_BIT  = 2;
   localparam int unsigned STAT_OVF_BIT   = 3;
   localparam int unsigned STAT_COUNT_LSB = 8;
   localparam int unsigned STAT_COUNT_W   = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// MEM-stage data-bus bundle shared with RAM.
//   address    : data address
//   write_data : store data (rs2)
//   wren       : one-cycle store strobe
//   read_data  : registered load data, one cycle after the address
interface mmio_uart_tx_if #(
   parameter int unsigned ADDR_WIDTH = 15
);
   logic [ADDR_WIDTH-1:0] address;
   logic [31:0]           write_data;
   logic                  wren;
   logic [31:0]           read_data;

   modport master (output address, output write_data, output wren, input read_data);
   modport slave  (input address, input write_data, input wren, output read_data);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write strobe and data (ignored when full unless popping)
//   pop, dout  : read strobe and head-of-queue data
//   full, empty, count : occupancy
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push_c, do_pop_c;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
   assign do_pop_c  = pop & ~empty;
   assign do_push_c = push & (~full | do_pop_c);

   // Pointer/count next state; pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push_c) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop_c)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push_c, do_pop_c})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push_c) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter on the MEM-stage data bus.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of the data bus (address, write_data, wren, read_data)
//   txd        : 8N1 serial output, idle high
//   tx_busy    : high while a frame is on the line
module mmio_uart_tx
   import mmio_pkg::*;
#(
   parameter int unsigned CLK_PER_BIT = 868,
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned ADDR_WIDTH  = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   mmio_uart_tx_if.slave        bus,
   output logic                 txd,
   output logic                 tx_busy
);
   localparam int unsigned BAUD_W = $clog2(CLK_PER_BIT);
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BAUD_W-1:0]     BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
   localparam logic [ADDR_WIDTH-1:0] TX_ADDR   = ADDR_WIDTH'(TX_DATA_ADDR);
   localparam logic [ADDR_WIDTH-1:0] ST_ADDR   = ADDR_WIDTH'(STATUS_ADDR);

   tx_state_t         state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              txd_q, txd_d;
   logic              busy_q, busy_d;
   logic              ovf_q, ovf_d;
   logic [31:0]       read_data_q, read_data_d;

   logic              sel_tx_c, sel_st_c, store_tx_c, store_st_c;
   logic              baud_end_c, pop_c, push_c;
   logic              fifo_full, fifo_empty;
   logic [7:0]        fifo_dout;
   logic [CNT_W-1:0]  fifo_count;
   logic [31:0]       status_c;
   logic              unused_wdata_c;

   assign sel_tx_c   = (bus.address == TX_ADDR);
   assign sel_st_c   = (bus.address == ST_ADDR);
   assign store_tx_c = bus.wren & sel_tx_c;
   assign store_st_c = bus.wren & sel_st_c;
   assign push_c     = store_tx_c;
   assign unused_wdata_c = ^bus.write_data[31:8];

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_c),
      .pop   (pop_c),
      .din   (bus.write_data[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Serialiser next state: start/data/stop bits, popping the next byte as each frame ends.
   always_comb begin
      state_d    = state_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      baud_d     = baud_q;
      pop_c      = 1'b0;
      txd_d      = 1'b1;
      baud_end_c = (baud_q == BAUD_LAST);

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop_c   = 1'b1;
               shift_d = fifo_dout;
               state_d = START;
            end
         end
         START: begin
            if (baud_end_c) begin
               state_d = DATA;
               bit_d   = 3'd0;
            end
         end
         DATA: begin
            if (baud_end_c) begin
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end
         end
         STOP: begin
            if (baud_end_c) begin
               if (!fifo_empty) begin
                  pop_c   = 1'b1;
                  shift_d = fifo_dout;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Restart the bit timer on every state change and at each data-bit boundary.
      if (state_q == IDLE || state_d != state_q || baud_end_c) baud_d = '0;
      else                                                     baud_d = baud_q + 1'b1;

      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
         default: txd_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   // Sticky overflow: a store that finds the FIFO full with no pop in the same cycle is lost.
   always_comb begin
      ovf_d = ovf_q;
      if (store_tx_c && fifo_full && !pop_c)                   ovf_d = 1'b1;
      else if (store_st_c && bus.write_data[STAT_OVF_BIT])     ovf_d = 1'b0;
   end

   // Load data is built from pre-update state, matching RAM's one-cycle latency.
   always_comb begin
      status_c                                     = '0;
      status_c[STAT_FULL_BIT]                      = fifo_full;
      status_c[STAT_EMPTY_BIT]                     = fifo_empty;
      status_c[STAT_BUSY_BIT]                      = busy_q;
      status_c[STAT_OVF_BIT]                       = ovf_q;
      status_c[STAT_COUNT_LSB +: STAT_COUNT_W]     = STAT_COUNT_W'(fifo_count);
      read_data_d = sel_st_c ? status_c : 32'd0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         baud_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         txd_q       <= 1'b1;
         busy_q      <= 1'b0;
         ovf_q       <= 1'b0;
         read_data_q <= '0;
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         txd_q       <= txd_d;
         busy_q      <= busy_d;
         ovf_q       <= ovf_d;
         read_data_q <= read_data_d;
      end
   end

   assign txd           = txd_q;
   assign tx_busy       = busy_q;
   assign bus.read_data = read_data_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: two instances (fast baud / deep FIFO, slow baud / shallow FIFO),
// a serial-line monitor per instance checked against a queue of expected bytes, and
// status-register reads checked against hand-derived values.
module tb_mmio_uart_tx;
   import mmio_pkg::*;

   localparam int unsigned AW      = 15;
   localparam int unsigned CPB_A   = 4;
   localparam int unsigned DEPTH_A = 16;
   localparam int unsigned CPB_B   = 16;
   localparam int unsigned DEPTH_B = 4;
   localparam logic [AW-1:0] A_TX = AW'(TX_DATA_ADDR);
   localparam logic [AW-1:0] A_ST = AW'(STATUS_ADDR);

   logic clk = 1'b0;
   logic reset;
   logic txd_a, txd_b, busy_a, busy_b;

   always #5 clk = ~clk;

   mmio_uart_tx_if #(.ADDR_WIDTH(AW)) bus_a ();
   mmio_uart_tx_if #(.ADDR_WIDTH(AW)) bus_b ();

   mmio_uart_tx #(.CLK_PER_BIT(CPB_A), .FIFO_DEPTH(DEPTH_A), .ADDR_WIDTH(AW)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a), .txd(txd_a), .tx_busy(busy_a));

   mmio_uart_tx #(.CLK_PER_BIT(CPB_B), .FIFO_DEPTH(DEPTH_B), .ADDR_WIDTH(AW)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b), .txd(txd_b), .tx_busy(busy_b));

   int         n_vec = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         frames_a = 0;
   int         frames_b = 0;
   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];
   int         fall_a[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Store: drive at a falling edge, sampled on the next rising edge, released at the next falling edge.
   task automatic bus_store(input bit b, input logic [AW-1:0] addr, input logic [31:0] data);
      if (!b) begin
         bus_a.address = addr; bus_a.write_data = data; bus_a.wren = 1'b1;
      end else begin
         bus_b.address = addr; bus_b.write_data = data; bus_b.wren = 1'b1;
      end
      @(negedge clk);
      bus_a.wren = 1'b0;
      bus_b.wren = 1'b0;
   endtask

   // Store to the TX data register of a byte that is expected on the line.
   task automatic tx_byte(input bit b, input logic [7:0] data);
      if (!b) exp_a.push_back(data);
      else    exp_b.push_back(data);
      bus_store(b, A_TX, {24'h0, data});
   endtask

   task automatic bus_load(input bit b, input logic [AW-1:0] addr, output logic [31:0] data);
      if (!b) begin bus_a.address = addr; bus_a.wren = 1'b0; end
      else    begin bus_b.address = addr; bus_b.wren = 1'b0; end
      @(negedge clk);
      data = b ? bus_b.read_data : bus_a.read_data;
   endtask

   // Line monitors: detect the start edge, sample mid-bit, compare each byte with the scoreboard.
   bit         mon_act [2];
   int         mon_cnt [2];
   logic [7:0] mon_data[2];

   always @(negedge clk) begin
      int          cpb;
      int          k;
      logic        t;
      logic [31:0] exp;
      string       nm;
      for (int m = 0; m < 2; m++) begin
         cpb = (m == 0) ? CPB_A : CPB_B;
         t   = (m == 0) ? txd_a : txd_b;
         nm  = (m == 0) ? "A" : "B";
         if (reset) begin
            mon_act[m] = 1'b0;
         end else begin
            if (!mon_act[m] && t == 1'b0) begin
               mon_act[m] = 1'b1;
               mon_cnt[m] = 0;
               if (m == 0) fall_a.push_back(cyc);
            end
            if (mon_act[m]) begin
               if (mon_cnt[m] % cpb == cpb / 2) begin
                  k = mon_cnt[m] / cpb;
                  if (k == 0) begin
                     check_eq({nm, "_start_bit"}, 32'(t), 32'd0);
                  end else if (k <= 8) begin
                     mon_data[m][k-1] = t;
                  end else begin
                     check_eq({nm, "_stop_bit"}, 32'(t), 32'd1);
                     if (m == 0) exp = (exp_a.size() != 0) ? 32'(exp_a.pop_front()) : 32'h100;
                     else        exp = (exp_b.size() != 0) ? 32'(exp_b.pop_front()) : 32'h100;
                     check_eq({nm, "_frame_byte"}, 32'(mon_data[m]), exp);
                     if (m == 0) frames_a++;
                     else        frames_b++;
                     mon_act[m] = 1'b0;
                  end
               end
               mon_cnt[m]++;
            end
         end
      end
   end

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      reset = 1'b1;
      bus_a.address = '0; bus_a.write_data = '0; bus_a.wren = 1'b0;
      bus_b.address = '0; bus_b.write_data = '0; bus_b.wren = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_txd_a",  32'(txd_a),  32'd1);
      check_eq("rst_busy_a", 32'(busy_a), 32'd0);
      check_eq("rst_rd_a",   bus_a.read_data, 32'd0);
      check_eq("rst_txd_b",  32'(txd_b),  32'd1);
      check_eq("rst_rd_b",   bus_b.read_data, 32'd0);
      reset = 1'b0;

      // Idle after reset.
      repeat (100) @(negedge clk);
      check_eq("idle_txd_a",  32'(txd_a),  32'd1);
      check_eq("idle_busy_a", 32'(busy_a), 32'd0);
      bus_load(0, A_ST, rd); check_eq("idle_status_a", rd, 32'h0000_0002);
      bus_load(1, A_ST, rd); check_eq("idle_status_b", rd, 32'h0000_0002);
      bus_load(0, A_TX, rd); check_eq("load_txdata_a", rd, 32'h0);

      // Single byte: line stays high one cycle after the store edge, falls the next.
      tx_byte(0, 8'hA5);
      check_eq("a5_txd_n",  32'(txd_a),  32'd1);
      check_eq("a5_busy_n", 32'(busy_a), 32'd0);
      @(negedge clk);
      check_eq("a5_txd_n1",  32'(txd_a),  32'd0);
      check_eq("a5_busy_n1", 32'(busy_a), 32'd1);
      repeat (45) @(negedge clk);
      bus_load(0, A_ST, rd); check_eq("a5_status_done", rd, 32'h0000_0002);
      check_eq("a5_frames", 32'(frames_a), 32'd1);

      // Burst of three: count reads 2 right after the last store; frames abut exactly.
      fall_a.delete();
      tx_byte(0, 8'h01);
      tx_byte(0, 8'h02);
      tx_byte(0, 8'h03);
      bus_load(0, A_ST, rd); check_eq("burst_status", rd, 32'h0000_0204);
      repeat (125) @(negedge clk);
      check_eq("burst_starts", 32'(fall_a.size()), 32'd3);
      if (fall_a.size() == 3) begin
         check_eq("burst_gap01", 32'(fall_a[1] - fall_a[0]), 32'(10 * CPB_A));
         check_eq("burst_gap12", 32'(fall_a[2] - fall_a[1]), 32'(10 * CPB_A));
      end
      bus_load(0, A_ST, rd); check_eq("burst_status_done", rd, 32'h0000_0002);
      check_eq("burst_frames", 32'(frames_a), 32'd4);

      // Overflow on the shallow instance: one in flight, four buffered, sixth dropped.
      tx_byte(1, 8'h11);
      tx_byte(1, 8'h22);
      tx_byte(1, 8'h33);
      tx_byte(1, 8'h44);
      tx_byte(1, 8'h55);
      bus_store(1, A_TX, 32'h0000_0066);
      bus_load(1, A_ST, rd); check_eq("ovf_status_set", rd, 32'h0000_040D);
      bus_store(1, A_ST, 32'h0000_0008);
      bus_load(1, A_ST, rd); check_eq("ovf_status_clr", rd, 32'h0000_0405);
      repeat (900) @(negedge clk);
      bus_load(1, A_ST, rd); check_eq("ovf_status_done", rd, 32'h0000_0002);
      check_eq("ovf_frames", 32'(frames_b), 32'd5);

      // Push into a full FIFO on the exact edge the stop bit ends and pops.
      tx_byte(1, 8'h80);
      tx_byte(1, 8'h81);
      tx_byte(1, 8'h82);
      tx_byte(1, 8'h83);
      tx_byte(1, 8'h84);
      repeat (10 * CPB_B - 4) @(negedge clk);
      tx_byte(1, 8'h85);
      bus_load(1, A_ST, rd); check_eq("fullpop_status", rd, 32'h0000_0405);
      repeat (900) @(negedge clk);
      bus_load(1, A_ST, rd); check_eq("fullpop_status_done", rd, 32'h0000_0002);
      check_eq("fullpop_frames", 32'(frames_b), 32'd11);

      // Reset in the middle of the data bits with a second byte still queued.
      tx_byte(0, 8'h77);
      tx_byte(0, 8'h88);
      repeat (8) @(negedge clk);
      check_eq("midrst_busy_pre", 32'(busy_a), 32'd1);
      reset = 1'b1;
      exp_a.delete();
      @(negedge clk);
      check_eq("midrst_txd",  32'(txd_a),  32'd1);
      check_eq("midrst_busy", 32'(busy_a), 32'd0);
      check_eq("midrst_rd",   bus_a.read_data, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      bus_load(0, A_ST, rd); check_eq("midrst_status", rd, 32'h0000_0002);
      tx_byte(0, 8'h3C);
      repeat (45) @(negedge clk);
      bus_load(0, A_ST, rd); check_eq("post_rst_status", rd, 32'h0000_0002);
      check_eq("post_rst_frames", 32'(frames_a), 32'd5);

      check_eq("pending_a", 32'(exp_a.size()), 32'd0);
      check_eq("pending_b", 32'(exp_b.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
